instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of the control unit. Owns the program counter and drives
//  word addresses to the instruction ROM over a req/ack handshake. Hands each
//  18-bit instruction and its PC downstream on a valid/ready handshake.
//  Taken jumps arrive on the redirect port; the unit flushes in-flight work and
//  restarts fetching at the target.
// PARAMETERS
//  ADDR_W    10  ROM word-address width; PC wraps modulo 2**ADDR_W
//  INSTR_W   18  instruction width
//  RESET_PC  0   first fetch address after reset or start
// PORTS
//  clock           in   1        clock; all state updates on posedge
//  reset           in   1        reset, synchronous, active-high
//  start           in   1        1-cycle pulse: begin fetching at RESET_PC
//  rom_req         out  1        ROM read request; held until rom_ack
//  rom_addr        out  ADDR_W   ROM address; stable while rom_req=1
//  rom_ack         in   1        1-cycle pulse; rom_data valid in this cycle
//  rom_data        in   INSTR_W  ROM read data
//  instr_valid     out  1        instr_data/instr_pc hold a fetched instruction
//  instr_data      out  INSTR_W  instruction word
//  instr_pc        out  ADDR_W   address the instruction was fetched from
//  instr_ready     in   1        consumer accepts when instr_valid & instr_ready
//  redirect_valid  in   1        1-cycle pulse: jump taken
//  redirect_addr   in   ADDR_W   jump target
// BEHAVIOUR
//  - Reset: state=IDLE; pc=RESET_PC; rom_req=0, rom_addr=0, instr_valid=0,
//    instr_data=0, instr_pc=0; drop flag cleared. Reset overrides all other inputs.
//  - States:
//    - IDLE: wait for start. On start go to REQ, with pc=RESET_PC.
//    - REQ: rom_req=1, rom_addr=pc. Leave REQ only on rom_ack.
//    - HOLD: instruction is presented downstream (instr_valid=1).
//  - Transfer: on rom_ack in REQ with drop=0, register the instruction next
//    cycle: instr_valid=1, instr_data=rom_data, instr_pc=pc. Then pc<=pc+1
//    (wraps 1023->0) and go to HOLD. Minimum latency is req->ack + 1 cycle.
//  - HOLD: on instr_valid & instr_ready, clear instr_valid and go to REQ.
//    The outputs stay stable while instr_ready=0.
//  - Redirect (any non-IDLE state): pc<=redirect_addr. In the same cycle,
//    instr_valid<=0; an instruction handshaking in that cycle counts as consumed.
//  - Redirect while rom_req=1 and no ack yet: rom_addr must stay stable, so set
//    drop=1. The next ack's data is discarded, drop clears, and the unit
//    re-requests at redirect_addr.
//  - Redirect in the same cycle as rom_ack: the data is discarded and no drop is
//    set. Next cycle the unit requests redirect_addr.
//  - A second redirect before the pending ack: the latest target wins; drop stays 1.
//  - start while not IDLE is ignored. Only reset returns the unit to IDLE.
//  - rom_ack outside REQ is ignored (protocol error; assertion in sim).
// CONFIGURATION
//  FETCH_PREFETCH_EN defined:
//   - A 2-entry instruction FIFO replaces the single output register.
//   - The unit keeps issuing requests while the FIFO has a free slot not already
//     reserved by an outstanding request, giving back-to-back delivery when the
//     ROM acks in 1 cycle.
//   - instr_valid = FIFO not empty.
//   - Redirect flushes the FIFO and drops outstanding data as described above.
//  FETCH_PREFETCH_EN undefined:
//   - Single-register IDLE/REQ/HOLD behaviour above; no overlap of request and hold.
//   - At most 1 instruction per (ack latency + 2) cycles.
// STRUCTURE
//  - cpu_pkg: ADDR_W/INSTR_W constants, RESET_PC, fetch_state_t enum
//    {IDLE, REQ, HOLD}, opcode constants for the JUMP..JBE range (used by
//    assertions only).
//  - Sub-module fetch_fifo (2-entry, {pc,instr} wide, with sync flush),
//    instantiated only under FETCH_PREFETCH_EN.
// TESTING
//  - reset, then start, ROM acks after 1 cycle with 0x00C0A, ready=1 ->
//    rom_addr=0, then instr_valid with instr_data=0x00C0A and instr_pc=0;
//    next request at addr 1.
//  - ready held 0 for 5 cycles while valid -> instr_data/instr_pc unchanged,
//    rom_req=0 (prefetch off); accept on cycle 6 -> request at pc+1.
//  - redirect to 0x155 while rom_req is pending at addr 4 ->
//    addr 4 stays stable until ack; that data is never valid downstream;
//    next request at 0x155.
//  - pc at 0x3FF, instruction accepted -> next rom_addr=0x000.
//  - reset asserted mid-REQ with redirect_valid=1 in the same cycle ->
//    IDLE, all outputs 0, no further requests until start.
//  - FETCH_PREFETCH_EN, 1-cycle ack, ready=1 -> after fill, one instruction per
//    cycle with consecutive instr_pc values. Redirect -> FIFO flushed; first new
//    instr_pc = target.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: bus widths, reset PC, fetch FSM states.
// Jump opcodes mark the contiguous JUMP..JBE range in the top six instruction bits.
package cpu_pkg;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 18;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OPC_JUMP = 6'h20;
    localparam logic [5:0] OPC_JBE  = 6'h26;

    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        return (instr[INSTR_W-1 -: 6] >= OPC_JUMP) && (instr[INSTR_W-1 -: 6] <= OPC_JBE);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM req/ack read port, downstream valid/ready instruction port, redirect input.
// master = fetch unit side, slave = ROM / consumer / branch-resolution side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);
    logic               rom_req;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;

    modport master (
        output rom_req, rom_addr, instr_valid, instr_data, instr_pc,
        input  rom_ack, rom_data, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  rom_req, rom_addr, instr_valid, instr_data, instr_pc,
        output rom_ack, rom_data, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue between ROM responses and the downstream consumer.
// Latency: pushed entry visible at head next cycle. Backpressure: caller never pushes when full; flush empties it.
module fetch_fifo #(
    parameter int WIDTH = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (pop)  rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
        end else if (push && !flush) begin
            slot[wr_ptr] <= push_data;
        end
    end

    assign head  = slot[rd_ptr];
    assign empty = (count == 2'd0);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction ROM (req/ack), hands {pc, instr} downstream (valid/ready).
// Latency: ROM ack + 1 cycle. Backpressure: instr_ready=0 freezes the output register and stops fetching.
// FETCH_PREFETCH_EN: 2-entry FIFO replaces the output register, fetching continues while a slot is free.
module instr_fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    instr_fetch_unit_if.master bus
);
    import cpu_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              rom_req_q;
    logic              drop;

    assign pc_inc       = pc + ADDR_W'(1);
    assign bus.rom_req  = rom_req_q;
    assign bus.rom_addr = rom_addr_q;

`ifdef FETCH_PREFETCH_EN
    logic                      push;
    logic                      pop;
    logic                      flush;
    logic                      fifo_empty;
    logic [1:0]                fifo_count;
    logic [1:0]                fill_next;
    logic [ADDR_W+INSTR_W-1:0] fifo_head;

    assign push      = (state == REQ) && bus.rom_ack && !drop && !bus.redirect_valid;
    assign pop       = !fifo_empty && bus.instr_ready;
    assign flush     = bus.redirect_valid && (state != IDLE);
    // Occupancy after this cycle; a new request may only claim a slot still free then.
    assign fill_next = fifo_count + 2'(push) - 2'(pop);

    fetch_fifo #(.WIDTH(ADDR_W + INSTR_W)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({pc, bus.rom_data}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.instr_valid                 = !fifo_empty;
    assign {bus.instr_pc, bus.instr_data}  = fifo_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= REQ;
                    pc         <= RESET_PC;
                    rom_req_q  <= 1'b1;
                    rom_addr_q <= RESET_PC;
                end
                REQ: begin
                    if (bus.redirect_valid) begin
                        pc <= bus.redirect_addr;
                        if (bus.rom_ack) begin
                            rom_addr_q <= bus.redirect_addr;
                            drop       <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (bus.rom_ack) begin
                        if (drop) begin
                            drop       <= 1'b0;
                            rom_addr_q <= pc;
                        end else begin
                            pc <= pc_inc;
                            if (fill_next < 2'd2) begin
                                rom_addr_q <= pc_inc;
                            end else begin
                                rom_req_q <= 1'b0;
                                state     <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc         <= bus.redirect_addr;
                        state      <= REQ;
                        rom_req_q  <= 1'b1;
                        rom_addr_q <= bus.redirect_addr;
                    end else if (fill_next < 2'd2) begin
                        state      <= REQ;
                        rom_req_q  <= 1'b1;
                        rom_addr_q <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_data_q;
    logic [ADDR_W-1:0]  instr_pc_q;

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_data  = instr_data_q;
    assign bus.instr_pc    = instr_pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            rom_req_q     <= 1'b0;
            rom_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= REQ;
                    pc         <= RESET_PC;
                    rom_req_q  <= 1'b1;
                    rom_addr_q <= RESET_PC;
                end
                REQ: begin
                    // rom_addr must not move under a pending request, so a redirect only retargets pc.
                    if (bus.redirect_valid) begin
                        pc <= bus.redirect_addr;
                        if (bus.rom_ack) begin
                            rom_addr_q <= bus.redirect_addr;
                            drop       <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (bus.rom_ack) begin
                        if (drop) begin
                            drop       <= 1'b0;
                            rom_addr_q <= pc;
                        end else begin
                            instr_valid_q <= 1'b1;
                            instr_data_q  <= bus.rom_data;
                            instr_pc_q    <= pc;
                            pc            <= pc_inc;
                            rom_req_q     <= 1'b0;
                            state         <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid) begin
                        pc            <= bus.redirect_addr;
                        instr_valid_q <= 1'b0;
                        state         <= REQ;
                        rom_req_q     <= 1'b1;
                        rom_addr_q    <= bus.redirect_addr;
                    end else if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state         <= REQ;
                        rom_req_q     <= 1'b1;
                        rom_addr_q    <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    a_ack_only_in_req: assert property (@(posedge clock) disable iff (reset)
        bus.rom_ack |-> (state == REQ));

    a_addr_stable: assert property (@(posedge clock) disable iff (reset)
        (bus.rom_req && !bus.rom_ack) |=> (bus.rom_req && $stable(bus.rom_addr)));

    a_jump_pc_known: assert property (@(posedge clock) disable iff (reset)
        (bus.instr_valid && is_jump(bus.instr_data)) |-> !$isunknown(bus.instr_pc));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a credit-gated ROM model checks request addresses,
// a monitor checks every downstream handshake against the expected {pc, instr} queue.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [9:0]  pc;
        logic [17:0] data;
    } item_t;

    logic clock = 1'b0;
    logic reset;
    logic start;

    always #5 clock = ~clock;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         credits = 0;
    int         lat = 0;
    int         cyc = 0;
    int         pend;
    item_t      exp_q[$];
    logic [9:0] exp_addr_q[$];
    int         cons_cyc[$];

    function automatic logic [17:0] rom_word(input logic [9:0] a);
        if (a == 10'd0) return 18'h00C0A;
        return {a, 8'h5A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_addr_q.size() != 0); i++) step();
        check({name, "_drain_left"}, 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && !bus.instr_valid; i++) step();
        check({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
    endtask

    always @(posedge clock) cyc++;

    // ROM model: acks only while credits remain, after lat extra cycles; checks address stability.
    initial begin
        int         wait_cnt;
        logic       prev_req;
        logic       prev_ack;
        logic [9:0] prev_addr;
        logic [9:0] ea;
        wait_cnt = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        bus.rom_ack = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(negedge clock);
            bus.rom_ack = 1'b0;
            if (!reset && bus.rom_req) begin
                if (prev_req && !prev_ack) check("rom_addr_stable", 32'(bus.rom_addr), 32'(prev_addr));
                if (credits > 0 && wait_cnt >= lat) begin
                    bus.rom_ack = 1'b1;
                    bus.rom_data = rom_word(bus.rom_addr);
                    credits--;
                    wait_cnt = 0;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rom_unexpected_req: got addr %0h expected no request", bus.rom_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("rom_addr", 32'(bus.rom_addr), 32'(ea));
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_req = bus.rom_req;
            prev_ack = bus.rom_ack;
            prev_addr = bus.rom_addr;
        end
    end

    // Monitor: every accepted instruction must be the next expected one.
    initial begin
        item_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.instr_valid && bus.instr_ready) begin
                cons_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_unexpected: got pc %0h data %0h expected none", bus.instr_pc, bus.instr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
                    check("instr_data", 32'(bus.instr_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = '0;
        repeat (3) step();
        check("rst_rom_req", 32'(bus.rom_req), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_data", 32'(bus.instr_data), 32'd0);
        check("rst_pc", 32'(bus.instr_pc), 32'd0);
        reset = 1'b0;
        step();
        check("idle_no_req", 32'(bus.rom_req), 32'd0);

        // Basic fetch from RESET_PC, 1-cycle ROM, consumer always ready.
        exp_addr_q = '{10'h000, 10'h001, 10'h002};
        exp_q.push_back('{10'h000, 18'h00C0A});
        exp_q.push_back('{10'h001, 18'h0015A});
        exp_q.push_back('{10'h002, 18'h0025A});
        bus.instr_ready = 1'b1;
        credits = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("first_req_addr", 32'(bus.rom_addr), 32'd0);
        wait_drained("t1");
        step();
        check("t1_next_req", 32'(bus.rom_req), 32'd1);
        check("t1_next_addr", 32'(bus.rom_addr), 32'h003);
        pend = 3;

`ifndef FETCH_PREFETCH_EN
        // Backpressure: output frozen, no new request while held.
        bus.instr_ready = 1'b0;
        exp_addr_q.push_back(10'h003);
        exp_q.push_back('{10'h003, 18'h0035A});
        credits = 1;
        wait_valid("t2");
        for (int i = 0; i < 5; i++) begin
            check("hold_data", 32'(bus.instr_data), 32'h0035A);
            check("hold_pc", 32'(bus.instr_pc), 32'h003);
            check("hold_no_req", 32'(bus.rom_req), 32'd0);
            step();
        end
        bus.instr_ready = 1'b1;
        step();
        check("t2_next_req", 32'(bus.rom_req), 32'd1);
        check("t2_next_addr", 32'(bus.rom_addr), 32'h004);
        pend = 4;
`endif

        // Redirect while a request is pending: old address held, its data dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 10'h155;
        step();
        bus.redirect_valid = 1'b0;
        repeat (3) step();
        check("t3_pending_addr", 32'(bus.rom_addr), 32'(pend));
        exp_addr_q.push_back(10'(pend));
        exp_addr_q.push_back(10'h155);
        exp_q.push_back('{10'h155, 18'h1555A});
        credits = 2;
        wait_drained("t3");
        step();

        // PC wrap across 0x3FF with a slower ROM.
        lat = 2;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 10'h3FE;
        step();
        bus.redirect_valid = 1'b0;
        exp_addr_q = '{10'h156, 10'h3FE, 10'h3FF, 10'h000};
        exp_q.push_back('{10'h3FE, 18'h3FE5A});
        exp_q.push_back('{10'h3FF, 18'h3FF5A});
        exp_q.push_back('{10'h000, 18'h00C0A});
        credits = 4;
        wait_drained("t4");
        step();
        check("t4_wrap_next", 32'(bus.rom_addr), 32'h001);

        // Reset wins over a simultaneous redirect mid-request.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 10'h2AA;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        check("t5_rom_req", 32'(bus.rom_req), 32'd0);
        check("t5_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_data", 32'(bus.instr_data), 32'd0);
        check("t5_pc", 32'(bus.instr_pc), 32'd0);
        lat = 0;
        credits = 4;
        repeat (8) step();
        check("t5_stays_idle", 32'(bus.rom_req), 32'd0);
        credits = 0;
        exp_addr_q.push_back(10'h000);
        exp_q.push_back('{10'h000, 18'h00C0A});
        credits = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_drained("t5");
        step();

`ifndef FETCH_PREFETCH_EN
        // Redirect while holding an instruction: it is discarded, fetch restarts at target.
        bus.instr_ready = 1'b0;
        exp_addr_q.push_back(10'h001);
        credits = 1;
        wait_valid("t6");
        check("t6_hold_pc", 32'(bus.instr_pc), 32'h001);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 10'h010;
        step();
        bus.redirect_valid = 1'b0;
        check("t6_flushed", 32'(bus.instr_valid), 32'd0);
        check("t6_req_addr", 32'(bus.rom_addr), 32'h010);
        exp_addr_q.push_back(10'h010);
        exp_q.push_back('{10'h010, 18'h0105A});
        bus.instr_ready = 1'b1;
        credits = 1;
        wait_drained("t6");
`else
        // Streaming: one instruction per cycle once the FIFO is primed.
        cons_cyc.delete();
        for (int a = 1; a <= 6; a++) begin
            exp_addr_q.push_back(10'(a));
            exp_q.push_back('{10'(a), rom_word(10'(a))});
        end
        credits = 6;
        wait_drained("pf_stream");
        for (int i = 1; i < 6; i++) begin
            if (i < cons_cyc.size()) check("pf_back_to_back", 32'(cons_cyc[i] - cons_cyc[i-1]), 32'd1);
        end
        step();
        // Fill both slots, then redirect: FIFO flushed, first new pc is the target.
        bus.instr_ready = 1'b0;
        exp_addr_q.push_back(10'h007);
        exp_addr_q.push_back(10'h008);
        credits = 2;
        repeat (6) step();
        check("pf_full_no_req", 32'(bus.rom_req), 32'd0);
        check("pf_full_head_pc", 32'(bus.instr_pc), 32'h007);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 10'h200;
        step();
        bus.redirect_valid = 1'b0;
        check("pf_flushed", 32'(bus.instr_valid), 32'd0);
        exp_addr_q.push_back(10'h200);
        exp_q.push_back('{10'h200, 18'h2005A});
        bus.instr_ready = 1'b1;
        credits = 1;
        wait_drained("pf_redirect");
`endif

        repeat (3) step();
        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
